operand_entry_ctrl: RTL and testbench
=====================================

# operand_entry_ctrl

Keypad-side sequencer for the calculator datapath. Collects digit, sign, clear and enter keypresses into a 4-digit BCD display/entry register and drives it onto the combinational BCD-to-binary converter. Captures the converted signed value into operand A, then operand B, and hands the pair to the ALU with a valid/ready handshake. Sits between the keypad decoder and the arithmetic unit; also feeds the 7-segment display driver.

## Interface
- `CONV_WAIT`, default 1: cycles to wait after entering a CONV state before sampling `bin_in` (converter settle margin); legal range 1–7.
- `MAX_DIGITS`, default 3: number of magnitude digits accepted; fixed at 3 to match the converter's 0..999 range.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single system clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `key_valid`, in, 1: one-cycle strobe; `key_code` is valid.
- `key_code`, in, 4: key code.
  - 0x0–0x9: digit.
  - 0xA: negate.
  - 0xC: clear.
  - 0xE: enter.
  - Other codes are ignored.
- `key_ready`, out, 1: high in ENTER_A/ENTER_B; keys are ignored when low.
- `bcd0`, `bcd1`, `bcd2`, out, 4 each: magnitude digits, least significant first; 0xF = blank.
- `bcd3`, out, 4: sign digit; 0xB = minus, 0xF = blank.
- `bin_in`, in, 11 signed: converter result.
- `op_a`, `op_b`, out, 11 signed: captured operands.
- `op_valid`, out, 1: operand pair available.
- `op_ready`, in, 1: ALU accepts the pair.
- `phase_b`, out, 1: high while entering or converting operand B (display annunciator).

## Operation
- States:
  - ENTER_A, CONV_A, ENTER_B, CONV_B, OUT.
  - Reset state: ENTER_A.
- Digit key in ENTER_x, with `count < MAX_DIGITS`:
  - Shift: `bcd2<=bcd1`, `bcd1<=bcd0`, `bcd0<=key`.
  - `count++`.
  - Leading zeros count as digits.
  - Digit keys with `count == MAX_DIGITS` are ignored; no state change.
- Negate key in ENTER_x: toggles `bcd3` between 0xF and 0xB. Allowed with `count == 0`, giving −0, which converts to 0.
- Clear key in ENTER_A or ENTER_B:
  - All digits go to 0xF, `count` to 0.
  - `op_a` and `op_b` go to 0.
  - Next state is ENTER_A.
- Enter key in ENTER_A:
  - Go to CONV_A and load the wait counter with `CONV_WAIT`.
  - Entering with `count == 0` is legal; all digits blank converts to 0.
- CONV_A:
  - Decrement the wait counter each cycle.
  - At the cycle it reads 1: `op_a <= bin_in`, all digits go to 0xF, `count <= 0`, next state ENTER_B.
- ENTER_B and CONV_B behave identically, capturing into `op_b`; the next state after CONV_B is OUT.
- OUT:
  - `op_valid` stays high until a cycle with `op_ready` high.
  - On that cycle go to ENTER_A. `op_a` and `op_b` hold their values (ALU may re-read them); only the digits stay blank.
- In CONV_x and OUT, `key_valid` is ignored entirely; keys are not queued.
- Width rule: `bin_in` is captured unmodified, with no saturation. The range ±999 always fits in 11-bit signed.

## Timing
- Reset (async assert, sync release):
  - State ENTER_A.
  - `bcd0`–`bcd3` = 0xF.
  - `op_a` = `op_b` = 0.
  - `op_valid` = 0, `phase_b` = 0, `key_ready` = 1.
  - `count` = 0.
- All outputs are registered, except `key_ready` and `phase_b`, which are decoded from the state register.
- A key sampled at edge t updates `bcd*` after edge t.
- Enter sampled at edge t:
  - CONV_x after edge t.
  - Capture at edge t+`CONV_WAIT`.
  - ENTER_B / OUT after edge t+`CONV_WAIT`.
  - With `CONV_WAIT`=1, enter-to-next-entry latency is 2 edges.
- `op_valid` rises after the edge capturing `op_b`. It falls after the first edge with `op_ready`=1. If `op_ready` is already high, `op_valid` is high for exactly one cycle.
- `key_valid` in the same cycle as the CONV→ENTER transition is ignored, because `key_ready` is still low that cycle.
- Reset asserted mid-CONV or mid-OUT: immediate return to the reset values; a pending pair is discarded.

## Structure
- Shared `calc_pkg` holds:
  - Key-code constants (KEY_NEG=0xA, KEY_CLR=0xC, KEY_ENT=0xE).
  - Digit codes (BCD_BLANK=0xF, BCD_MINUS=0xB).
  - The state enum.
  - The operand width constant (11).
- One sub-module, `digit_entry_reg`:
  - Contains the 3-digit shift register, sign toggle and `count`.
  - Inputs: shift-in digit, negate, clear.
  - Instantiated once and reused for both operands.
- The BCD-to-binary converter is instantiated at the parent level, not inside this block.

## Test plan
- Keys 1, 2, 3, enter; 4, 5, enter; `op_ready`=1 → `op_a`=123, `op_b`=45, `op_valid` pulses one cycle, back in ENTER_A.
- Keys 7, negate, enter; negate, 9, 9, 9, enter → `op_a`=−7, `op_b`=−999; `bcd3`=0xB is shown during entry.
- Keys 1, 2, 3, 4 → digits show 1 2 3 (4 ignored), `count`=3; a clear then gives all digits 0xF and ENTER_A.
- Immediate enter, enter → `op_a`=0, `op_b`=0, `op_valid`=1; hold `op_ready`=0 for 5 cycles → `op_valid` stays high and digit keys are ignored.
- `CONV_WAIT`=3: enter at edge t → `op_a` updates at edge t+3 and not before; a key strobe during CONV_A leaves the digits unchanged.
- Assert `rst` during CONV_B → all outputs at reset values asynchronously, `op_valid` never asserts.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_pkg
//  Purpose  : Shared constants and types for the calculator datapath.
//             Key codes from the keypad decoder, special display digit
//             codes, the operand width and the operand-entry state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int OPERAND_W = 11;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_NEG       = 4'hA;
    localparam logic [3:0] KEY_CLR       = 4'hC;
    localparam logic [3:0] KEY_ENT       = 4'hE;

    localparam logic [3:0] BCD_BLANK     = 4'hF;
    localparam logic [3:0] BCD_MINUS     = 4'hB;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_CONV_A  = 3'd1,
        ST_ENTER_B = 3'd2,
        ST_CONV_B  = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/digit_entry_reg.sv
`default_nettype none
// ============================================================================
//  Module   : digit_entry_reg
//  Purpose  : Display/entry register for one operand: a shift register of
//             magnitude digits (new digit enters at bcd0), a sign digit that
//             toggles between blank and minus, and a digit count that stops
//             accepting digits once MAX_DIGITS have been entered.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             shift_en      - shift 'digit' in (ignored when full)
//             digit         - BCD digit to shift in
//             negate        - toggle sign digit
//             clear         - blank all digits, zero the count (priority)
//             bcd0..bcd2    - magnitude digits, LS first, 0xF = blank
//             bcd3          - sign digit, 0xB = minus, 0xF = blank
//  Revision : 1.0 - initial release
// ============================================================================
module digit_entry_reg
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_en,
    input  logic [3:0] digit,
    input  logic       negate,
    input  logic       clear,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd0  <= BCD_BLANK;
            bcd1  <= BCD_BLANK;
            bcd2  <= BCD_BLANK;
            bcd3  <= BCD_BLANK;
            count <= '0;
        end else if (clear) begin
            bcd0  <= BCD_BLANK;
            bcd1  <= BCD_BLANK;
            bcd2  <= BCD_BLANK;
            bcd3  <= BCD_BLANK;
            count <= '0;
        end else begin
            // Leading zeros are real digits, so the count advances on every
            // accepted digit regardless of its value.
            if (shift_en && (count < CNT_W'(MAX_DIGITS))) begin
                bcd2  <= bcd1;
                bcd1  <= bcd0;
                bcd0  <= digit;
                count <= count + CNT_W'(1);
            end
            if (negate) begin
                bcd3 <= (bcd3 == BCD_MINUS) ? BCD_BLANK : BCD_MINUS;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : operand_entry_ctrl
//  Purpose  : Keypad-side sequencer. Collects keys into the digit entry
//             register, waits CONV_WAIT cycles for the external BCD-to-binary
//             converter, captures operand A then operand B and presents the
//             pair to the ALU with a valid/ready handshake.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             key_valid, key_code - keypad strobe and code
//             key_ready           - keys accepted (ENTER_A / ENTER_B)
//             bcd0..bcd3          - display digits to converter / 7-seg
//             bin_in              - converter result (signed)
//             op_a, op_b          - captured operands
//             op_valid, op_ready  - operand pair handshake
//             phase_b             - entering/converting operand B
//  Revision : 1.0 - initial release
// ============================================================================
module operand_entry_ctrl
    import calc_pkg::*;
#(
    parameter int CONV_WAIT  = 1,
    parameter int MAX_DIGITS = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_valid,
    input  logic [3:0]                  key_code,
    output logic                        key_ready,
    output logic [3:0]                  bcd0,
    output logic [3:0]                  bcd1,
    output logic [3:0]                  bcd2,
    output logic [3:0]                  bcd3,
    input  logic signed [OPERAND_W-1:0] bin_in,
    output logic signed [OPERAND_W-1:0] op_a,
    output logic signed [OPERAND_W-1:0] op_b,
    output logic                        op_valid,
    input  logic                        op_ready,
    output logic                        phase_b
);

    state_t     state;
    state_t     next_state;
    logic [2:0] wait_cnt;

    logic       shift_en;
    logic       negate;
    logic       clear_digits;
    logic       clear_ops;
    logic       load_wait;
    logic       cap_a;
    logic       cap_b;
    logic       in_conv;

    assign key_ready = (state == ST_ENTER_A) || (state == ST_ENTER_B);
    assign phase_b   = (state == ST_ENTER_B) || (state == ST_CONV_B);
    assign in_conv   = (state == ST_CONV_A)  || (state == ST_CONV_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ENTER_A;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        shift_en     = 1'b0;
        negate       = 1'b0;
        clear_digits = 1'b0;
        clear_ops    = 1'b0;
        load_wait    = 1'b0;
        cap_a        = 1'b0;
        cap_b        = 1'b0;
        case (state)
            ST_ENTER_A, ST_ENTER_B: begin
                if (key_valid) begin
                    if (key_code <= KEY_DIGIT_MAX) begin
                        shift_en = 1'b1;
                    end else if (key_code == KEY_NEG) begin
                        negate = 1'b1;
                    end else if (key_code == KEY_CLR) begin
                        clear_digits = 1'b1;
                        clear_ops    = 1'b1;
                        next_state   = ST_ENTER_A;
                    end else if (key_code == KEY_ENT) begin
                        load_wait  = 1'b1;
                        next_state = (state == ST_ENTER_A) ? ST_CONV_A : ST_CONV_B;
                    end
                end
            end
            ST_CONV_A: begin
                if (wait_cnt == 3'd1) begin
                    cap_a        = 1'b1;
                    clear_digits = 1'b1;
                    next_state   = ST_ENTER_B;
                end
            end
            ST_CONV_B: begin
                if (wait_cnt == 3'd1) begin
                    cap_b        = 1'b1;
                    clear_digits = 1'b1;
                    next_state   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (op_ready) begin
                    next_state = ST_ENTER_A;
                end
            end
            default: begin
                next_state = ST_ENTER_A;
            end
        endcase
    end

    // Converter settle counter: loaded on enter, sampled-at-1 in CONV_x.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 3'd0;
        end else if (load_wait) begin
            wait_cnt <= 3'(CONV_WAIT);
        end else if (in_conv) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
        end else begin
            if (clear_ops) begin
                op_a <= '0;
                op_b <= '0;
            end
            if (cap_a) begin
                op_a <= bin_in;
            end
            if (cap_b) begin
                op_b     <= bin_in;
                op_valid <= 1'b1;
            end else if ((state == ST_OUT) && op_ready) begin
                op_valid <= 1'b0;
            end
        end
    end

    digit_entry_reg #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_digits (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .digit    (key_code),
        .negate   (negate),
        .clear    (clear_digits),
        .bcd0     (bcd0),
        .bcd1     (bcd1),
        .bcd2     (bcd2),
        .bcd3     (bcd3)
    );

endmodule
`default_nettype wire

// File: tb/tb_operand_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_entry_ctrl
//  Purpose  : Self-checking bench for operand_entry_ctrl. Two instances share
//             the keypad inputs: one with CONV_WAIT=1, one with CONV_WAIT=3.
//             A behavioural BCD-to-binary converter feeds each bin_in.
//             Expected operand pairs are queued as keys are driven and popped
//             when op_valid rises.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_entry_ctrl;

    localparam logic [3:0] K_NEG = 4'hA;
    localparam logic [3:0] K_CLR = 4'hC;
    localparam logic [3:0] K_ENT = 4'hE;

    typedef struct {
        logic signed [10:0] a;
        logic signed [10:0] b;
    } pair_t;

    logic clk;
    logic rst;
    logic key_valid;
    logic [3:0] key_code;
    logic op_ready;

    logic key_ready, op_valid, phase_b;
    logic [3:0] bcd0, bcd1, bcd2, bcd3;
    logic signed [10:0] bin_in, op_a, op_b;

    logic key_ready3, op_valid3, phase_b3;
    logic [3:0] bcd0_3, bcd1_3, bcd2_3, bcd3_3;
    logic signed [10:0] bin_in3, op_a3, op_b3;

    pair_t sb[$];
    int errors = 0;
    int checks = 0;

    function automatic logic signed [10:0] conv(input logic [3:0] d0, input logic [3:0] d1,
                                                input logic [3:0] d2, input logic [3:0] s);
        int mag;
        mag = ((d2 == 4'hF) ? 0 : int'(d2)) * 100 +
              ((d1 == 4'hF) ? 0 : int'(d1)) * 10 +
              ((d0 == 4'hF) ? 0 : int'(d0));
        return (s == 4'hB) ? 11'(-mag) : 11'(mag);
    endfunction

    assign bin_in  = conv(bcd0, bcd1, bcd2, bcd3);
    assign bin_in3 = conv(bcd0_3, bcd1_3, bcd2_3, bcd3_3);

    operand_entry_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .bcd0      (bcd0),
        .bcd1      (bcd1),
        .bcd2      (bcd2),
        .bcd3      (bcd3),
        .bin_in    (bin_in),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .phase_b   (phase_b)
    );

    operand_entry_ctrl #(.CONV_WAIT(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready3),
        .bcd0      (bcd0_3),
        .bcd1      (bcd1_3),
        .bcd2      (bcd2_3),
        .bcd3      (bcd3_3),
        .bin_in    (bin_in3),
        .op_a      (op_a3),
        .op_b      (op_b3),
        .op_valid  (op_valid3),
        .op_ready  (op_ready),
        .phase_b   (phase_b3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Called at a falling edge: key is sampled on the next rising edge and
    // its effect is visible when this task returns.
    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic push(input logic signed [10:0] a, input logic signed [10:0] b);
        pair_t p;
        p.a = a;
        p.b = b;
        sb.push_back(p);
    endtask

    task automatic wait_out();
        int n;
        pair_t e;
        n = 0;
        while (!op_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("op_valid_rise", op_valid, 1);
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_op_a", op_a, e.a);
            chk("sb_op_b", op_b, e.b);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bcd0"}, bcd0, 4'hF);
        chk({tag, "_bcd1"}, bcd1, 4'hF);
        chk({tag, "_bcd2"}, bcd2, 4'hF);
        chk({tag, "_bcd3"}, bcd3, 4'hF);
        chk({tag, "_op_a"}, op_a, 0);
        chk({tag, "_op_b"}, op_b, 0);
        chk({tag, "_op_valid"}, op_valid, 0);
        chk({tag, "_phase_b"}, phase_b, 0);
        chk({tag, "_key_ready"}, key_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        op_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // 123 enter, 45 enter, ready high
        press(4'd1); press(4'd2); press(4'd3);
        chk("t1_bcd0", bcd0, 3);
        chk("t1_bcd1", bcd1, 2);
        chk("t1_bcd2", bcd2, 1);
        chk("t1_bcd3", bcd3, 4'hF);
        press(K_ENT);
        chk("t1_conv_key_ready", key_ready, 0);
        press(4'd9);                    // lands on the CONV->ENTER edge: ignored
        chk("t1_op_a", op_a, 123);
        chk("t1_blank_after_conv", bcd0, 4'hF);
        chk("t1_phase_b", phase_b, 1);
        chk("t1_key_ready_b", key_ready, 1);
        press(4'd4); press(4'd5);
        push(11'sd123, 11'sd45);
        press(K_ENT);
        wait_out();
        @(negedge clk);
        chk("t1_op_valid_pulse", op_valid, 0);
        chk("t1_back_enter_a", key_ready, 1);
        chk("t1_phase_a", phase_b, 0);
        chk("t1_op_a_hold", op_a, 123);

        // 7 neg enter, neg 999 enter
        press(4'd7); press(K_NEG);
        chk("t2_sign", bcd3, 4'hB);
        chk("t2_bcd0", bcd0, 7);
        press(K_ENT);
        @(negedge clk);
        chk("t2_op_a", op_a, -7);
        press(K_NEG); press(4'd9); press(4'd9); press(4'd9);
        chk("t2_sign_b", bcd3, 4'hB);
        chk("t2_bcd2", bcd2, 9);
        push(-11'sd7, -11'sd999);
        press(K_ENT);
        wait_out();
        @(negedge clk);
        chk("t2_op_valid_pulse", op_valid, 0);

        // 1234 -> 4th digit ignored, then clear
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("t3_bcd0", bcd0, 3);
        chk("t3_bcd1", bcd1, 2);
        chk("t3_bcd2", bcd2, 1);
        press(K_CLR);
        chk("t3_clr_bcd0", bcd0, 4'hF);
        chk("t3_clr_bcd2", bcd2, 4'hF);
        chk("t3_clr_op_a", op_a, 0);
        chk("t3_clr_op_b", op_b, 0);
        chk("t3_clr_phase", phase_b, 0);
        chk("t3_clr_ready", key_ready, 1);

        // empty enter, empty enter, ALU stalls
        op_ready = 1'b0;
        press(K_ENT);
        @(negedge clk);
        push(11'sd0, 11'sd0);
        press(K_ENT);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1;
            key_code  = 4'd5;
            @(negedge clk);
            chk("t4_hold_valid", op_valid, 1);
            chk("t4_key_ignored", bcd0, 4'hF);
            chk("t4_key_ready", key_ready, 0);
        end
        key_valid = 1'b0;
        op_ready  = 1'b1;
        @(negedge clk);
        chk("t4_valid_drop", op_valid, 0);
        chk("t4_enter_a", key_ready, 1);

        // CONV_WAIT=3 instance
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        press(4'd8);
        press(K_ENT);                   // sampled at edge t
        chk("t5_t0_op_a", op_a3, 0);
        chk("t5_t0_ready", key_ready3, 0);
        press(4'd5);                    // edge t+1, CONV_A: ignored
        chk("t5_t1_op_a", op_a3, 0);
        chk("t5_t1_bcd0", bcd0_3, 8);
        chk("t5_t1_bcd1", bcd1_3, 4'hF);
        @(negedge clk);                 // edge t+2
        chk("t5_t2_op_a", op_a3, 0);
        chk("t5_t2_ready", key_ready3, 0);
        @(negedge clk);                 // edge t+3
        chk("t5_t3_op_a", op_a3, 8);
        chk("t5_t3_ready", key_ready3, 1);
        chk("t5_t3_phase_b", phase_b3, 1);
        chk("t5_t3_bcd0", bcd0_3, 4'hF);
        chk("t5_t3_bcd2", bcd2_3, 4'hF);
        chk("t5_t3_bcd3", bcd3_3, 4'hF);
        chk("t5_t3_op_b", op_b3, 0);
        chk("t5_t3_valid", op_valid3, 0);

        // reset during CONV_B
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        press(4'd1);
        press(K_ENT);
        @(negedge clk);
        press(4'd2);
        press(K_ENT);
        chk("t6_in_conv_b", phase_b, 1);
        chk("t6_conv_ready", key_ready, 0);
        chk("t6_op_a_pre", op_a, 1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("t6_async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_valid", op_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
